// File: rtl/shft_rx.sv
// Serial-to-parallel byte receiver (LSB- or MSB-first) with sync framing and an output FIFO.
// Byte visible on out_valid one cycle after its 8th bit; a full FIFO without a same-cycle pop drops the byte and pulses overrun.
module shft_rx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat,
    output logic         ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   level;
    logic          full;
    logic          pop;
    logic          wr;

    assign full    = (level == FULL_LVL);
    assign out_vld = (level != '0);
    assign out_dat = mem[rptr];
    assign pop     = out_vld && out_rdy;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr      = in_vld && (!full || pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            ovf   <= 1'b0;
        end else begin
            if (wr) begin
                mem[wptr] <= in_dat;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            if (wr && !pop)
                level <= level + 1'b1;
            else if (!wr && pop)
                level <= level - 1'b1;
            ovf <= in_vld && full && !pop;
        end
    end
endmodule

module shft_rx #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sin,
    input  logic       sin_en,
    input  logic       dir,
    input  logic       sync,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overrun,
    output logic       frame_err
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    logic [0:0] state;
    logic [2:0] cnt;
    logic [7:0] acc;
    logic       dir_q;

    logic       cap;
    logic       bit0;
    logic       use_dir;
    logic       push;
    logic [2:0] cur_cnt;
    logic [7:0] acc_base;
    logic [7:0] acc_nxt;

    // sync restarts framing before the coincident bit is considered, so that bit is bit 0.
    always_comb begin
        cap      = sin_en && (sync || (state == RECV));
        cur_cnt  = sync ? 3'd0 : cnt;
        bit0     = cap && (cur_cnt == 3'd0);
        use_dir  = bit0 ? dir : dir_q;
        acc_base = sync ? 8'h00 : acc;
        acc_nxt  = use_dir ? {sin, acc_base[7:1]} : {acc_base[6:0], sin};
        push     = cap && (cur_cnt == 3'd7);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            acc       <= 8'h00;
            dir_q     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (sync) state <= RECV;
            if (cap) begin
                acc <= acc_nxt;
                cnt <= cur_cnt + 3'd1;
            end else if (sync) begin
                acc <= 8'h00;
                cnt <= 3'd0;
            end
            if (bit0) dir_q <= dir;
            frame_err <= sync && (state == RECV) && (cnt != 3'd0);
        end
    end

    shft_rx_fifo #(
        .W     (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .in_vld  (push),
        .in_dat  (acc_nxt),
        .out_vld (out_valid),
        .out_rdy (out_ready),
        .out_dat (out_data),
        .ovf     (overrun)
    );
endmodule

// File: tb/tb_shft_rx.sv
// Randomized and directed bench for shft_rx; a bit-list reference model feeds a scoreboard checked by a negedge monitor.
module tb_shft_rx;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sin = 1'b0;
    logic       sin_en = 1'b0;
    logic       dir = 1'b0;
    logic       sync = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       overrun;
    logic       frame_err;

    shft_rx #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sin       (sin),
        .sin_en    (sin_en),
        .dir       (dir),
        .sync      (sync),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ovr;
        bit ferr;
        bit vld;
    } exp_t;

    exp_t       pq[$];
    logic [7:0] exp_q[$];
    int         checks = 0;
    int         failures = 0;
    bit         mon_en = 1'b0;

    bit m_synced;
    bit m_dir;
    bit m_bits[$];
    int m_lvl;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: collect bits of the current byte, then weight them by position.
    task automatic cyc(input bit s, input bit en, input bit d, input bit sy, input bit rdy);
        exp_t e;
        int   v;
        bit   done;
        sin = s; sin_en = en; dir = d; sync = sy; out_ready = rdy;
        e.ferr = sy && m_synced && (m_bits.size() != 0);
        e.ovr  = 1'b0;
        done   = 1'b0;
        v      = 0;
        if (sy) begin
            m_bits.delete();
            m_synced = 1'b1;
        end
        if (en && m_synced) begin
            if (m_bits.size() == 0) m_dir = d;
            m_bits.push_back(s);
            if (m_bits.size() == 8) begin
                for (int i = 0; i < 8; i++)
                    v += int'(m_bits[i]) << (m_dir ? i : 7 - i);
                m_bits.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (m_lvl == DEPTH && !(rdy && m_lvl > 0)) begin
                e.ovr = 1'b1;
            end else begin
                exp_q.push_back(v[7:0]);
                m_lvl++;
            end
        end
        if (rdy && (m_lvl - (done && !e.ovr ? 1 : 0)) > 0) m_lvl--;
        e.vld = (m_lvl != 0);
        pq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit d, input bit sy,
                             input int gap_max, input bit rdy, input bit rdy_last);
        for (int i = 0; i < 8; i++) begin
            bit b;
            b = d ? v[i] : v[7-i];
            cyc(b, 1'b1, (i == 0) ? d : 1'($urandom_range(0, 1)), sy && (i == 0),
                (i == 7) ? rdy_last : rdy);
            if (i < 7 && gap_max > 0) begin
                int g;
                g = $urandom_range(0, gap_max);
                for (int k = 0; k < g; k++)
                    cyc(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0, rdy);
            end
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic do_reset(input int n);
        mon_en = 1'b0;
        rstn   = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_data", out_data, 8'h00);
        for (int k = 0; k < n; k++) begin
            sin = 1'($urandom_range(0, 1)); sin_en = 1'($urandom_range(0, 1));
            sync = 1'($urandom_range(0, 1)); dir = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk("rst_valid", out_valid, 0);
            chk("rst_data", out_data, 8'h00);
            chk("rst_overrun", overrun, 0);
            chk("rst_frame_err", frame_err, 0);
        end
        sin = 0; sin_en = 0; sync = 0; dir = 0; out_ready = 0;
        rstn = 1'b1;
        pq.delete();
        exp_q.delete();
        m_bits.delete();
        m_synced = 1'b0;
        m_dir    = 1'b0;
        m_lvl    = 0;
        pq.push_back('{ovr: 1'b0, ferr: 1'b0, vld: 1'b0});
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (pq.size() == 0) begin
                chk("pulse_queue_underflow", 1, 0);
            end else begin
                exp_t e;
                e = pq.pop_front();
                chk("overrun", overrun, e.ovr);
                chk("frame_err", frame_err, e.ferr);
                chk("out_valid", out_valid, e.vld);
                if (e.vld) begin
                    if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
                    else begin
                        chk("out_data", out_data, exp_q[0]);
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        do_reset(4);
        // No sync after reset: bits are ignored.
        for (int k = 0; k < 16; k++) cyc(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0, 1'b0);

        send_byte(8'hA5, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        idle(1, 1'b0);
        idle(2, 1'b1);

        send_byte(8'h3C, 1'b0, 1'b1, 3, 1'b0, 1'b0);
        idle(1, 1'b1);
        idle(1, 1'b0);

        // Overrun: third byte dropped with DEPTH=2.
        send_byte(8'h11, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        send_byte(8'h33, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // Full FIFO with a pop coinciding with the push.
        send_byte(8'h11, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle(4, 1'b1);

        // Resync mid-byte, then a complete byte with the sync bit as bit 0.
        for (int k = 0; k < 3; k++) cyc(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0, 1'b0);
        send_byte(8'h5A, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        idle(1, 1'b0);
        idle(2, 1'b1);

        // Reset mid-byte and with a full FIFO.
        send_byte(8'h77, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        send_byte(8'h88, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        do_reset(2);
        for (int k = 0; k < 12; k++) cyc(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 600; k++)
            cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)));
        idle(4, 1'b1);

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shft_rx.md
# shft_rx

Serial-to-parallel receiver for the byte-wide shift register's serial output. It samples the serial bit stream one qualified bit at a time and reassembles bytes in either bit order, LSB-first (dir=1) or MSB-first (dir=0). Completed bytes go into a small output FIFO with a valid/ready interface. Framing is set by an explicit sync strobe, and errors are reported as single-cycle pulses.

## Interface
- DEPTH, 2, output FIFO entries (power of two, ≥2)
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- sin  in  1  serial data bit (shifter cout)
- sin_en  in  1  sin is a valid bit this cycle
- dir  in  1  bit order: 1 = LSB first, 0 = MSB first; latched at bit 0 of each byte
- sync  in  1  start-of-frame strobe; next/coincident bit is bit 0
- out_data  out  8  FIFO head byte
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts head when out_valid=1
- overrun  out  1  one-cycle pulse: completed byte dropped, FIFO full
- frame_err  out  1  one-cycle pulse: sync discarded a partial byte

## Operation
- Reset state:
  - FSM IDLE; bit counter cnt=0; accumulator 0; latched dir 0.
  - FIFO empty, storage 0.
  - out_data=0x00, out_valid=0, overrun=0, frame_err=0.
- FSM states IDLE and RECV.
  - IDLE: sin_en is ignored unless sync=1. On sync, go to RECV with cnt=0. If sin_en=1 in the same cycle, that bit is captured as bit 0 and cnt becomes 1.
  - RECV: each sin_en=1 cycle shifts one bit in and increments cnt (3 bits, wraps 7→0). RECV is left only by reset.
- Shift rules:
  - latched dir=1: acc <= {sin, acc[7:1]}.
  - latched dir=0: acc <= {acc[6:0], sin}.
  - dir is latched on every bit-0 capture (cnt==0 and sin_en=1). Mid-byte changes of dir have no effect.
- Byte completion (cnt==7 and sin_en=1):
  - The shifted value, including the current bit, is pushed to the FIFO.
  - cnt returns to 0. Back-to-back bytes need no further sync.
- sync in RECV:
  - Discards the partial byte and sets cnt=0, or cnt=1 if sin_en coincides, capturing that bit as bit 0.
  - frame_err pulses if the old cnt≠0. No pulse if cnt==0.
  - If sync coincides with the 8th bit, sync wins: the byte is not pushed and frame_err pulses.
- FIFO:
  - out_data is the head entry; pop on out_valid & out_ready. Order is strictly FIFO.
  - Push while full without a same-cycle pop: the byte is dropped, overrun pulses, and FIFO contents are unchanged.
  - Push while full with a same-cycle pop: both happen, no overrun, level unchanged.
  - Pop while empty: no effect.
- Level counter width: $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.

## Timing
- Latency: the 8th sin_en edge to out_valid=1 and out_data valid is 1 cycle, i.e. registered on that same edge and visible afterwards.
- out_valid and out_data change only at clock edges. out_data holds stable while out_valid=1 and out_ready=0.
- overrun and frame_err are registered. Each is high for exactly the cycle after the offending edge.
- Maximum throughput: one bit per cycle, one byte per 8 cycles. FIFO drain: one byte per cycle.
- rstn low at any time, including mid-byte or with a full FIFO: outputs immediately take reset values, the partial byte and FIFO contents are lost, and the FSM returns to IDLE. After release, a new sync is required.

## Test plan
- Reset: hold rstn=0 with random sin/sin_en/sync → out_valid=0, out_data=0x00, overrun=0, frame_err=0. With no sync after release, 16 sin_en bits → out_valid stays 0.
- LSB first: sync with first sin_en, dir=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles → out_valid=1 the cycle after the 8th bit, out_data=0xA5. out_ready=1 → out_valid=0 next cycle.
- MSB first with gaps: dir=0, bits 0,0,1,1,1,1,0,0 with sin_en idle cycles interleaved, dir toggled mid-byte → out_data=0x3C.
- Overrun: DEPTH=2, out_ready=0, 24 contiguous bits for 0x11, 0x22, 0x33 → overrun is a single pulse after the 24th bit. Drain yields 0x11 then 0x22, then out_valid=0.
- Full push plus pop: FIFO holding 0x11, 0x22, out_ready=1 on the cycle the 8th bit of 0x44 arrives → no overrun. Sequence 0x11, 0x22, 0x44.
- Resync and reset: 3 bits, then sync with a coincident bit, then 7 more bits of 0x5A → frame_err single pulse, out_data=0x5A. Assert rstn=0 mid-byte → out_valid=0, and the partial byte never appears.
